// File: rtl/re_map_pkg.sv
// Shared types and constants for the PUSCH RE-map scheduler.
// State enum, grid sizing and address width.
package re_map_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    MAP,
    SYM_END,
    DONE
  } state_e;

  localparam int TOTAL_SC = 1200;
  localparam int N_SYM    = 14;
  localparam int SC_W     = 11;
  localparam int SYM_W    = 4;
  localparam int ADDR_W   = SYM_W + SC_W;

endpackage

// File: rtl/re_map_cfg_check.sv
// Combinational validity check of a slot allocation.
// In: n_sc, n_rb, sym_start, sym_end. Out: cfg_ok.
module re_map_cfg_check
  import re_map_pkg::*;
#(
  parameter int Total_Sc = TOTAL_SC
) (
  input  logic [10:0] n_sc,
  input  logic [6:0]  n_rb,
  input  logic [3:0]  sym_start,
  input  logic [3:0]  sym_end,
  output logic        cfg_ok
);

  logic [12:0] re_end;

  assign re_end = 13'(n_sc)
                + {3'b000, n_rb, 3'b000}
                + {4'b0000, n_rb, 2'b00};

  assign cfg_ok = (n_rb != 7'd0)
               && (re_end <= 13'(Total_Sc))
               && (sym_end >= sym_start)
               && (sym_end <= 4'(N_SYM - 1));

endmodule

// File: rtl/re_map_scheduler.sv
// Slot sequencer: walks symbols, pulls DMRS/FFT samples, writes grid.
// Ports: cfg/Start/Abort in, DMRS+FFT valid/ready, grid write + status out.
module re_map_scheduler
  import re_map_pkg::*;
#(
  parameter int FFT_Len  = 18,
  parameter int DMRS_Len = 9,
  parameter int Total_Sc = TOTAL_SC
) (
  input  logic                       CLK_RE,
  input  logic                       RST_RE,
  input  logic                       Start,
  input  logic                       Abort,
  input  logic [10:0]                Cfg_N_sc,
  input  logic [6:0]                 Cfg_N_rb,
  input  logic [3:0]                 Cfg_Sym_Start,
  input  logic [3:0]                 Cfg_Sym_End,
  input  logic [13:0]                Cfg_Dmrs_Mask,
  input  logic signed [DMRS_Len-1:0] Dmrs_I,
  input  logic signed [DMRS_Len-1:0] Dmrs_Q,
  input  logic                       Dmrs_Valid,
  output logic                       Dmrs_Ready,
  input  logic signed [FFT_Len-1:0]  Fft_I,
  input  logic signed [FFT_Len-1:0]  Fft_Q,
  input  logic                       Fft_Valid,
  output logic                       Fft_Ready,
  output logic                       Sym_Req,
  output logic                       Sym_Is_Dmrs,
  output logic [3:0]                 Sym_Idx,
  output logic                       Grid_We,
  output logic [ADDR_W-1:0]          Grid_Addr,
  output logic signed [FFT_Len-1:0]  RE_Real,
  output logic signed [FFT_Len-1:0]  RE_Imj,
  output logic                       Sym_Done,
  output logic                       Slot_Done,
  output logic                       Busy,
  output logic                       Cfg_Err
);

  state_e state_q, state_d;

  logic [3:0]  sym_q;
  logic [3:0]  sym_end_q;
  logic [10:0] k_q;
  logic [10:0] n_sc_q;
  logic [10:0] len_m1_q;
  logic [13:0] mask_q;
  logic        cfg_err_q;

  logic        cfg_ok;
  logic [10:0] cfg_len;
  logic        is_dmrs;
  logic        in_map;
  logic        dmrs_fire;
  logic        fft_fire;
  logic        gap_wr;
  logic        wr;
  logic        last_re;
  logic        start_ok;
  logic        start_bad;
  logic [10:0] sc_addr;

  logic signed [FFT_Len-1:0] dmrs_i_ext;
  logic signed [FFT_Len-1:0] dmrs_q_ext;
  logic signed [FFT_Len-1:0] re_i_d;
  logic signed [FFT_Len-1:0] re_q_d;

  re_map_cfg_check #(
    .Total_Sc (Total_Sc)
  ) u_cfg_check (
    .n_sc      (Cfg_N_sc),
    .n_rb      (Cfg_N_rb),
    .sym_start (Cfg_Sym_Start),
    .sym_end   (Cfg_Sym_End),
    .cfg_ok    (cfg_ok)
  );

  assign cfg_len = {1'b0, Cfg_N_rb, 3'b000}
                 + {2'b00, Cfg_N_rb, 2'b00};

  assign is_dmrs = mask_q[sym_q];
  assign in_map  = (state_q == MAP);

  // Ready comes from registered state and k only.
  assign Dmrs_Ready = in_map & is_dmrs & ~k_q[0];
  assign Fft_Ready  = in_map & ~is_dmrs;

  assign dmrs_fire = Dmrs_Valid & Dmrs_Ready;
  assign fft_fire  = Fft_Valid & Fft_Ready;
  // Odd k of a DMRS symbol writes a zero without a handshake.
  assign gap_wr    = in_map & is_dmrs & k_q[0];
  assign wr        = dmrs_fire | fft_fire | gap_wr;
  assign last_re   = (k_q == len_m1_q);

  assign start_ok  = (state_q == IDLE) & Start & ~Abort & cfg_ok;
  assign start_bad = (state_q == IDLE) & Start & ~Abort & ~cfg_ok;

  assign sc_addr    = n_sc_q + k_q;
  assign dmrs_i_ext = FFT_Len'(Dmrs_I);
  assign dmrs_q_ext = FFT_Len'(Dmrs_Q);

  always_ff @(posedge CLK_RE or posedge RST_RE) begin
    if (RST_RE) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (Abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start_ok) state_d = SETUP;
        SETUP:   state_d = MAP;
        MAP:     if (wr && last_re) state_d = SYM_END;
        SYM_END: state_d = (sym_q == sym_end_q) ? DONE : SETUP;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_RE or posedge RST_RE) begin
    if (RST_RE) begin
      sym_q     <= '0;
      sym_end_q <= '0;
      k_q       <= '0;
      n_sc_q    <= '0;
      len_m1_q  <= '0;
      mask_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= start_bad;
      if (Abort) begin
        sym_q     <= '0;
        sym_end_q <= '0;
        k_q       <= '0;
        n_sc_q    <= '0;
        len_m1_q  <= '0;
        mask_q    <= '0;
      end else begin
        if (start_ok) begin
          sym_q     <= Cfg_Sym_Start;
          sym_end_q <= Cfg_Sym_End;
          n_sc_q    <= Cfg_N_sc;
          len_m1_q  <= cfg_len - 11'd1;
          mask_q    <= Cfg_Dmrs_Mask;
        end
        unique case (state_q)
          SETUP: k_q <= '0;
          MAP:   if (wr) k_q <= k_q + 11'd1;
          SYM_END:
            if (sym_q != sym_end_q) sym_q <= sym_q + 4'd1;
          DONE:  sym_q <= '0;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    re_i_d = '0;
    re_q_d = '0;
    unique case (1'b1)
      dmrs_fire: begin
        re_i_d = dmrs_i_ext;
        re_q_d = dmrs_q_ext;
      end
      fft_fire: begin
        re_i_d = Fft_I;
        re_q_d = Fft_Q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_RE or posedge RST_RE) begin
    if (RST_RE) begin
      Grid_We   <= 1'b0;
      Grid_Addr <= '0;
      RE_Real   <= '0;
      RE_Imj    <= '0;
    end else begin
      Grid_We <= wr & ~Abort;
      if (wr && !Abort) begin
        Grid_Addr <= {sym_q, sc_addr};
        RE_Real   <= re_i_d;
        RE_Imj    <= re_q_d;
      end
    end
  end

  assign Sym_Req     = (state_q == SETUP);
  assign Sym_Is_Dmrs = Sym_Req & is_dmrs;
  assign Sym_Idx     = sym_q;
  assign Sym_Done    = (state_q == SYM_END);
  assign Slot_Done   = (state_q == DONE);
  assign Busy        = (state_q != IDLE);
  assign Cfg_Err     = cfg_err_q;

endmodule
